// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Serialises fetch and execute accesses onto the single-port memory.
//            Stores are posted as a write right after their read. Build option
//            MEM_ARB_RR_EN selects round-robin instead of execute priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int READ_ADDR_SIZE = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_readEn,
  input  logic [READ_ADDR_SIZE-1:0] fetch_readAddr,
  output logic                      fetch_readFin,
  output logic [XLEN-1:0]           fetch_readData,
  input  logic                      ex_readEn,
  input  logic [READ_ADDR_SIZE-1:0] ex_readAddr,
  output logic                      ex_readFin,
  output logic [XLEN-1:0]           ex_readData,
  input  logic                      ex_writeEn,
  input  logic [READ_ADDR_SIZE-1:0] ex_writeAddr,
  input  logic [XLEN-1:0]           ex_writeData,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [READ_ADDR_SIZE-1:0] mem_addr,
  output logic [XLEN-1:0]           mem_wdata,
  input  logic                      mem_ack,
  input  logic [XLEN-1:0]           mem_rdata,
  output logic                      arb_busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_FETCH = 2'd1,
    RD_EX    = 2'd2,
    WR_POST  = 2'd3
  } state_t;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_EX    = 1'b1;

  state_t                    state_q, state_d;
  logic [READ_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [XLEN-1:0]           wdata_q, wdata_d;
  logic                      last_grant_q, last_grant_d;
  logic                      grant_ex;
  logic                      grant_fetch;

  always_comb begin
`ifdef MEM_ARB_RR_EN
    // On contention, hand the grant to whoever was not served last.
    grant_ex = ex_readEn & (~fetch_readEn | (last_grant_q == GRANT_FETCH));
`else
    grant_ex = ex_readEn;
`endif
    grant_fetch = fetch_readEn & ~grant_ex;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= GRANT_FETCH;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    last_grant_d  = last_grant_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    fetch_readFin = 1'b0;
    ex_readFin    = 1'b0;
    case (state_q)
      IDLE: begin
        // Any mem_ack seen here is stale and deliberately ignored.
        if (grant_ex) begin
          state_d      = RD_EX;
          addr_d       = ex_readAddr;
          last_grant_d = GRANT_EX;
        end else if (grant_fetch) begin
          state_d      = RD_FETCH;
          addr_d       = fetch_readAddr;
          last_grant_d = GRANT_FETCH;
        end
      end
      RD_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          fetch_readFin = 1'b1;
          state_d       = IDLE;
        end
      end
      RD_EX: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ex_readFin = 1'b1;
          if (ex_writeEn) begin
            addr_d  = ex_writeAddr;
            wdata_d = ex_writeData;
            state_d = WR_POST;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WR_POST: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fetch_readData = fetch_readFin ? mem_rdata : '0;
  assign ex_readData    = ex_readFin    ? mem_rdata : '0;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign arb_busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Scoreboard bench for mem_port_arbiter with a latency-programmable
//            memory model; expected transactions are queued as stimulus is driven.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int WHO_FETCH = 0;
  localparam int WHO_EX    = 1;
  localparam int WHO_WR    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetch_readEn = 1'b0;
  logic [31:0] fetch_readAddr = '0;
  logic        fetch_readFin;
  logic [31:0] fetch_readData;
  logic        ex_readEn = 1'b0;
  logic [31:0] ex_readAddr = '0;
  logic        ex_readFin;
  logic [31:0] ex_readData;
  logic        ex_writeEn = 1'b0;
  logic [31:0] ex_writeAddr = '0;
  logic [31:0] ex_writeData = '0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        arb_busy;

  mem_port_arbiter #(.XLEN(32), .READ_ADDR_SIZE(32)) dut (
    .clk(clk), .rst(rst),
    .fetch_readEn(fetch_readEn), .fetch_readAddr(fetch_readAddr),
    .fetch_readFin(fetch_readFin), .fetch_readData(fetch_readData),
    .ex_readEn(ex_readEn), .ex_readAddr(ex_readAddr),
    .ex_readFin(ex_readFin), .ex_readData(ex_readData),
    .ex_writeEn(ex_writeEn), .ex_writeAddr(ex_writeAddr), .ex_writeData(ex_writeData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          who;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          acks_seen = 0;
  int          lat = 1;
  bit          ack_en = 1'b1;
  bit          force_ack = 1'b0;
  int          mem_cnt = 0;
  int          req_len = 0;
  logic [31:0] mem_model [logic [31:0]];

  function automatic logic [31:0] def_rd(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory model: acks after lat extra request cycles; junk rdata otherwise.
  always @(negedge clk) begin
    mem_ack   = force_ack;
    mem_rdata = 32'hBAD0_0000 | mem_cnt;
    if (mem_req && !rst) begin
      if (ack_en && mem_cnt >= lat) begin
        mem_ack = 1'b1;
        mem_cnt = 0;
        if (mem_we) mem_model[mem_addr] = mem_wdata;
        else if (mem_model.exists(mem_addr)) mem_rdata = mem_model[mem_addr];
        else mem_rdata = def_rd(mem_addr);
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // Scoreboard monitor, sampling half a cycle away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst) begin
      if (mem_req) req_len++;
      else req_len = 0;
      if (mem_req && mem_ack) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_txn: addr=%h we=%b, no transaction expected", mem_addr, mem_we);
        end else begin
          e = exp_q.pop_front();
          if (mem_we !== (e.who == WHO_WR) || mem_addr !== e.addr || arb_busy !== 1'b1 ||
              fetch_readFin !== (e.who == WHO_FETCH) || ex_readFin !== (e.who == WHO_EX)) begin
            n_fail++;
            $display("FAIL txn_ctrl: got we=%b addr=%h busy=%b ffin=%b efin=%b, want who=%0d addr=%h",
                     mem_we, mem_addr, arb_busy, fetch_readFin, ex_readFin, e.who, e.addr);
          end
          if ((e.who == WHO_WR && mem_wdata !== e.data) ||
              (e.who == WHO_FETCH && (fetch_readData !== e.data || ex_readData !== 32'h0)) ||
              (e.who == WHO_EX && (ex_readData !== e.data || fetch_readData !== 32'h0))) begin
            n_fail++;
            $display("FAIL txn_data: got wdata=%h fdata=%h edata=%h, want who=%0d data=%h",
                     mem_wdata, fetch_readData, ex_readData, e.who, e.data);
          end
          if (req_len != lat + 1) begin
            n_fail++;
            $display("FAIL req_len: mem_req high %0d cycles, want %0d", req_len, lat + 1);
          end
        end
        acks_seen++;
        req_len = 0;
      end else begin
        n_tests++;
        if (fetch_readFin !== 1'b0 || ex_readFin !== 1'b0 ||
            fetch_readData !== 32'h0 || ex_readData !== 32'h0) begin
          n_fail++;
          $display("FAIL idle_fin: ffin=%b efin=%b fdata=%h edata=%h, want all 0",
                   fetch_readFin, ex_readFin, fetch_readData, ex_readData);
        end
      end
    end
  end

  task automatic wait_acks(input int target, input string name);
    int g = 0;
    while (acks_seen < target && g < 300) begin
      @(posedge clk);
      g++;
    end
    if (acks_seen < target) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: saw %0d acks, want %0d", name, acks_seen, target);
    end
    #1;
  endtask

  task automatic push(input int who, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.who = who; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetch_readEn = 1'b0; ex_readEn = 1'b0; ex_writeEn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    n_tests++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || fetch_readFin !== 1'b0 || ex_readFin !== 1'b0 ||
        arb_busy !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_state: req=%b we=%b ffin=%b efin=%b busy=%b addr=%h wdata=%h, want 0",
               mem_req, mem_we, fetch_readFin, ex_readFin, arb_busy, mem_addr, mem_wdata);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_fetch_only();
    int base = acks_seen;
    lat = 2;
    mem_model[32'h100] = 32'hDEADBEEF;
    push(WHO_FETCH, 32'h100, 32'hDEADBEEF);
    fetch_readEn = 1'b1; fetch_readAddr = 32'h100;
    wait_acks(base + 1, "fetch_only");
    fetch_readEn = 1'b0;
  endtask

  task automatic test_priority();
    int base;
    do_reset();
    base = acks_seen;
    lat = 1;
    push(WHO_EX, 32'h180, def_rd(32'h180));
    push(WHO_FETCH, 32'h1C0, def_rd(32'h1C0));
    ex_readEn = 1'b1; ex_readAddr = 32'h180;
    fetch_readEn = 1'b1; fetch_readAddr = 32'h1C0;
    wait_acks(base + 1, "prio_ex");
    ex_readEn = 1'b0;
    @(negedge clk); #2;
    n_tests++;
    if (mem_req !== 1'b0 || arb_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_idle_gap: req=%b busy=%b, want 0 0", mem_req, arb_busy);
    end
    @(negedge clk); #2;
    n_tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h1C0) begin
      n_fail++;
      $display("FAIL prio_fetch_grant: req=%b we=%b addr=%h, want 1 0 000001c0", mem_req, mem_we, mem_addr);
    end
    wait_acks(base + 2, "prio_fetch");
    fetch_readEn = 1'b0;
  endtask

  task automatic test_round_robin();
    int base;
    do_reset();
    base = acks_seen;
    lat = 1;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      if (i % 2 == 0) push(WHO_EX, 32'h300, def_rd(32'h300));
      else            push(WHO_FETCH, 32'h400, def_rd(32'h400));
`else
      push(WHO_EX, 32'h300, def_rd(32'h300));
`endif
    end
    ex_readEn = 1'b1; ex_readAddr = 32'h300;
    fetch_readEn = 1'b1; fetch_readAddr = 32'h400;
    wait_acks(base + 4, "rr");
    ex_readEn = 1'b0; fetch_readEn = 1'b0;
  endtask

  task automatic test_store_post();
    int base = acks_seen;
    lat = 2;
    push(WHO_EX, 32'h200, def_rd(32'h200));
    push(WHO_WR, 32'h200, 32'h12345678);
    push(WHO_FETCH, 32'h200, 32'h12345678);
    ex_readEn = 1'b1; ex_readAddr = 32'h200;
    ex_writeEn = 1'b1; ex_writeAddr = 32'h200; ex_writeData = 32'h12345678;
    wait_acks(base + 1, "store_rd");
    ex_readEn = 1'b0; ex_writeEn = 1'b0;
    fetch_readEn = 1'b1; fetch_readAddr = 32'h200;
    wait_acks(base + 3, "store_fetch");
    fetch_readEn = 1'b0;
    // Store to a different address than the read, then a plain load.
    lat = 1;
    push(WHO_EX, 32'h240, def_rd(32'h240));
    push(WHO_WR, 32'h244, 32'hCAFEF00D);
    push(WHO_EX, 32'h244, 32'hCAFEF00D);
    ex_readEn = 1'b1; ex_readAddr = 32'h240;
    ex_writeEn = 1'b1; ex_writeAddr = 32'h244; ex_writeData = 32'hCAFEF00D;
    wait_acks(base + 4, "store2_rd");
    ex_readEn = 1'b0; ex_writeEn = 1'b0;
    wait_acks(base + 5, "store2_wr");
    ex_readEn = 1'b1; ex_readAddr = 32'h244;
    wait_acks(base + 6, "store2_load");
    ex_readEn = 1'b0;
  endtask

  task automatic test_reset_abort();
    ack_en = 1'b0;
    ex_readEn = 1'b1; ex_readAddr = 32'h500;
    ex_writeEn = 1'b1; ex_writeAddr = 32'h504; ex_writeData = 32'h0BAD0BAD;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin
      n_fail++;
      $display("FAIL abort_pending: req=%b addr=%h, want 1 00000500", mem_req, mem_addr);
    end
    rst = 1'b1;
    ex_readEn = 1'b0; ex_writeEn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ack_en = 1'b1;
    force_ack = 1'b1;
    @(negedge clk); #2;
    n_tests++;
    if (mem_req !== 1'b0 || arb_busy !== 1'b0 || fetch_readFin !== 1'b0 || ex_readFin !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stale_ack: req=%b busy=%b ffin=%b efin=%b, want 0", mem_req, arb_busy,
               fetch_readFin, ex_readFin);
    end
    @(posedge clk); #1 force_ack = 1'b0;
    @(negedge clk); #2;
    n_tests++;
    if (mem_req !== 1'b0 || arb_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_after: req=%b busy=%b, want 0 0", mem_req, arb_busy);
    end
  endtask

  task automatic test_back_to_back();
    int base = acks_seen;
    lat = 0;
    push(WHO_FETCH, 32'h600, def_rd(32'h600));
    fetch_readEn = 1'b1; fetch_readAddr = 32'h600;
    wait_acks(base + 1, "zero_lat");
    fetch_readEn = 1'b0;
    @(negedge clk); #2;
    n_tests++;
    if (mem_req !== 1'b0 || arb_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_lat_idle: req=%b busy=%b, want 0 0", mem_req, arb_busy);
    end
    // Request held through Fin is served again as a fresh transaction.
    push(WHO_FETCH, 32'h604, def_rd(32'h604));
    push(WHO_FETCH, 32'h604, def_rd(32'h604));
    push(WHO_EX, 32'h608, def_rd(32'h608));
    fetch_readEn = 1'b1; fetch_readAddr = 32'h604;
    wait_acks(base + 3, "b2b_fetch");
    fetch_readEn = 1'b0;
    ex_readEn = 1'b1; ex_readAddr = 32'h608;
    wait_acks(base + 4, "b2b_ex");
    ex_readEn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: %0d transactions never seen, want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_priority();
    test_round_robin();
    test_store_post();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
